agu_sequencer: RTL and testbench
================================

// Module: agu_sequencer
// PURPOSE
//  Control sequencer and 2-way arbiter for the address generation unit (AGU).
//  Two requesters (e.g. fetch, load/store) issue ops; the block grants one at a time, round-robin.
//  It drives the AGU compose/decompose strobes through a fixed FSM.
//  COMPOSE builds a 16-bit address from two bus bytes, low byte first; DECOMPOSE splits a 16-bit address into two bytes.
// PARAMETERS
//  TIMEOUT_CYCLES  16  max cycles waiting for a compose byte before abort; 0 disables timeout
// PORTS
//  clock                   in   1  single clock, rising edge
//  reset                   in   1  synchronous, active-high
//  req_valid               in   2  per-requester op request
//  req_op                  in   2  per-requester op: 0=COMPOSE, 1=DECOMPOSE
//  req_ready               out  2  one-hot accept; handshake when req_valid[i]&req_ready[i]
//  byte_in_valid           in   1  granted requester is driving the next compose byte on the data bus
//  byte_phase              out  1  byte being moved: 0=low, 1=high
//  byte_out_valid          out  1  AGU data_out holds a decompose byte (selected by byte_phase)
//  compose_write_low       out  1  AGU strobe
//  compose_write_high      out  1  AGU strobe
//  compose_read_enable     out  1  AGU strobe
//  decompose_write_enable  out  1  AGU strobe
//  decompose_read_low      out  1  AGU strobe
//  decompose_read_high     out  1  AGU strobe
//  grant                   out  2  one-hot owner of the current op; 0 when IDLE
//  busy                    out  1  FSM not in IDLE
//  done                    out  1  1-cycle pulse: op complete
//  error                   out  1  1-cycle pulse: compose timed out and was aborted
// BEHAVIOUR
//  - Reset: state=IDLE; every output 0; last_grant=1, so requester 0 wins the first tie; wait counter=0.
//    Reset mid-op abandons the op immediately. No done or error pulse is produced.
//  - AGU strobes are mutually exclusive: at most one is high in any cycle.
//  - IDLE arbitration:
//    - req_ready is asserted combinationally for the winner. Winner = the requester not equal to last_grant if it is valid, else the other valid one.
//    - On handshake (edge T): latch op and grant; last_grant <= winner.
//    - req_ready is 0 outside IDLE.
//  - COMPOSE path:
//    - C_LOW (byte_phase=0): compose_write_low = byte_in_valid. Advance when byte_in_valid=1, else hold.
//    - C_HIGH (byte_phase=1): same, using compose_write_high.
//    - C_READ: compose_read_enable=1 for 1 cycle.
//    - DONE: done=1. Address is valid on AGU address_out this cycle.
//  - DECOMPOSE path (never stalls):
//    - D_WRITE: decompose_write_enable=1.
//    - D_LOW: decompose_read_low=1.
//    - D_HIGH: decompose_read_high=1; byte_out_valid=1, byte_phase=0 (low byte on AGU).
//    - DONE: done=1; byte_out_valid=1, byte_phase=1 (high byte on AGU).
//  - Latency with no stalls: accept at T gives done at T+4 for both ops; DONE->IDLE.
//    Next accept earliest at T+5 (1 op per 5 cycles).
//  - Timeout: a wait counter runs in C_LOW/C_HIGH while byte_in_valid=0 and clears on each accepted byte.
//    When it reaches TIMEOUT_CYCLES (if nonzero): error=1 for 1 cycle, no strobe, next state IDLE, no done.
//  - grant holds its value from the cycle after accept through DONE/abort, and is 0 in IDLE.
//  - Requests arriving while busy are not queued; they must stay asserted until accepted.
// TESTING
//  1 Reset: reset=1 for 2 cycles with req_valid=2'b11 -> all outputs 0, req_ready=0; after release req_ready=2'b01.
//  2 Decompose: req0 op=1 accepted at T -> strobes dwe@T+1, drl@T+2, drh@T+3; byte_out_valid T+3 (phase 0), T+4 (phase 1);
//    done@T+4. With AGU address_in=16'hBEEF: bytes EF, BE.
//  3 Compose with stall: byte_in_valid low 3 cycles in C_LOW, then bytes 34, 12 -> cwl/cwh only when valid; AGU address_out=16'h1234 at done.
//  4 Round-robin: both valid continuously, 4 ops -> grants 01,10,01,10; req_ready never 2'b11.
//  5 Timeout: compose, byte_in_valid=0 forever -> error pulse exactly TIMEOUT_CYCLES cycles after entering C_LOW; no done; FSM back to IDLE.
//  6 Reset in C_HIGH -> next cycle IDLE, all strobes 0, no done/error pulse; next tie grants requester 0.

Source files
------------

// File: rtl/agu_sequencer_if.sv
// agu_sequencer_if: request/grant handshake and AGU strobe bundle for the AGU sequencer
//   req_valid[1:0]  requester -> seq  per-requester op request
//   req_op[1:0]     requester -> seq  per-requester op: 0=compose, 1=decompose
//   req_ready[1:0]  seq -> requester  one-hot accept
//   byte_in_valid   requester -> seq  next compose byte is on the data bus
//   byte_phase      seq -> bus        byte being moved: 0=low, 1=high
//   byte_out_valid  seq -> bus        AGU data_out holds a decompose byte
//   compose_*, decompose_*            one-hot AGU strobes
//   grant[1:0]      seq -> bus        owner of the current op
//   busy, done, error                 status; done/error are 1-cycle pulses
interface agu_sequencer_if;
   logic [1:0] req_valid;
   logic [1:0] req_op;
   logic [1:0] req_ready;
   logic [1:0] grant;
   logic byte_in_valid;
   logic byte_phase;
   logic byte_out_valid;
   logic compose_write_low;
   logic compose_write_high;
   logic compose_read_enable;
   logic decompose_write_enable;
   logic decompose_read_low;
   logic decompose_read_high;
   logic busy;
   logic done;
   logic error;
   modport master (
      output req_valid, req_op, byte_in_valid,
      input  req_ready, grant, byte_phase, byte_out_valid, compose_write_low, compose_write_high,
             compose_read_enable, decompose_write_enable, decompose_read_low, decompose_read_high,
             busy, done, error
   );
   modport slave (
      input  req_valid, req_op, byte_in_valid,
      output req_ready, grant, byte_phase, byte_out_valid, compose_write_low, compose_write_high,
             compose_read_enable, decompose_write_enable, decompose_read_low, decompose_read_high,
             busy, done, error
   );
endinterface

// File: rtl/agu_sequencer.sv
// agu_sequencer: round-robin 2-way arbiter and compose/decompose strobe sequencer for the AGU
//   clock  in  rising-edge clock
//   reset  in  synchronous active-high reset
//   bus    slave side of agu_sequencer_if (requests, AGU strobes, status)
module agu_sequencer #(
   parameter int TIMEOUT_CYCLES = 16
) (
   input logic clock,
   input logic reset,
   agu_sequencer_if.slave bus
);
   localparam int CW = $clog2(TIMEOUT_CYCLES + 2);
   localparam logic [CW-1:0] TLAST = CW'(TIMEOUT_CYCLES - 1);
   typedef enum logic [2:0] {IDLE, C_LOW, C_HIGH, C_READ, D_WRITE, D_LOW, D_HIGH, DONE} state_t;
   state_t state;
   logic last_grant;
   logic win;
   logic [CW-1:0] cnt;
   // prefer the requester that did not win last time, fall back to the other
   assign win = bus.req_valid[~last_grant] ? ~last_grant : last_grant;
   assign bus.req_ready = (!reset && state == IDLE && bus.req_valid[win]) ? (win ? 2'b10 : 2'b01) : 2'b00;
   // byte writes follow byte_in_valid directly; suppressed on the abort cycle
   assign bus.compose_write_low = !reset && state == C_LOW && bus.byte_in_valid && !bus.error;
   assign bus.compose_write_high = !reset && state == C_HIGH && bus.byte_in_valid && !bus.error;
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
         last_grant <= 1'b1;
         cnt <= '0;
         bus.grant <= 2'b00;
         bus.busy <= 1'b0;
         bus.done <= 1'b0;
         bus.error <= 1'b0;
         bus.byte_phase <= 1'b0;
         bus.byte_out_valid <= 1'b0;
         bus.compose_read_enable <= 1'b0;
         bus.decompose_write_enable <= 1'b0;
         bus.decompose_read_low <= 1'b0;
         bus.decompose_read_high <= 1'b0;
      end else begin
         // registered outputs are loaded for the state being entered
         bus.done <= 1'b0;
         bus.error <= 1'b0;
         bus.byte_phase <= 1'b0;
         bus.byte_out_valid <= 1'b0;
         bus.compose_read_enable <= 1'b0;
         bus.decompose_write_enable <= 1'b0;
         bus.decompose_read_low <= 1'b0;
         bus.decompose_read_high <= 1'b0;
         case (state)
            IDLE: if (|bus.req_ready) begin
               bus.grant <= bus.req_ready;
               bus.busy <= 1'b1;
               last_grant <= win;
               cnt <= '0;
               if (bus.req_op[win]) begin
                  state <= D_WRITE;
                  bus.decompose_write_enable <= 1'b1;
               end else begin
                  state <= C_LOW;
               end
            end
            C_LOW, C_HIGH: begin
               if (bus.error) begin
                  state <= IDLE;
                  bus.grant <= 2'b00;
                  bus.busy <= 1'b0;
                  cnt <= '0;
               end else if (bus.byte_in_valid) begin
                  cnt <= '0;
                  if (state == C_LOW) begin
                     state <= C_HIGH;
                     bus.byte_phase <= 1'b1;
                  end else begin
                     state <= C_READ;
                     bus.compose_read_enable <= 1'b1;
                  end
               end else begin
                  bus.byte_phase <= state == C_HIGH;
                  // error lands on the cycle the counter reaches TIMEOUT_CYCLES
                  if (TIMEOUT_CYCLES != 0) begin
                     cnt <= cnt + 1'b1;
                     bus.error <= cnt == TLAST;
                  end
               end
            end
            C_READ: begin
               state <= DONE;
               bus.done <= 1'b1;
            end
            D_WRITE: begin
               state <= D_LOW;
               bus.decompose_read_low <= 1'b1;
            end
            D_LOW: begin
               state <= D_HIGH;
               bus.decompose_read_high <= 1'b1;
               bus.byte_out_valid <= 1'b1;
            end
            D_HIGH: begin
               state <= DONE;
               bus.done <= 1'b1;
               bus.byte_out_valid <= 1'b1;
               bus.byte_phase <= 1'b1;
            end
            DONE: begin
               state <= IDLE;
               bus.grant <= 2'b00;
               bus.busy <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_agu_sequencer.sv
// tb_agu_sequencer: scoreboard bench for agu_sequencer with a behavioural AGU datapath
module tb_agu_sequencer;
   localparam int TO = 16;
   localparam logic [5:0] CWL = 6'b100000, CWH = 6'b010000, CRE = 6'b001000;
   localparam logic [5:0] DWE = 6'b000100, DRL = 6'b000010, DRH = 6'b000001, NON = 6'b000000;
   typedef struct {
      int cyc;
      logic [11:0] sig;
      logic [15:0] data;
   } exp_t;
   logic clock = 1'b0;
   logic reset = 1'b1;
   logic [7:0] data_bus = 8'h00;
   logic [15:0] address_in = 16'hBEEF;
   logic [15:0] comp_reg, address_out, dec_reg, obs_data;
   logic [7:0] data_out;
   logic [11:0] obs_sig;
   int cyc = 0, n_cmp = 0, n_bad = 0;
   bit mon_en = 1'b0;
   exp_t q[$];
   exp_t e;
   agu_sequencer_if bus();
   agu_sequencer #(.TIMEOUT_CYCLES(TO)) dut (.clock(clock), .reset(reset), .bus(bus));
   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;
   // AGU datapath driven by the sequencer strobes
   always @(posedge clock) begin
      if (bus.compose_write_low) comp_reg[7:0] <= data_bus;
      if (bus.compose_write_high) comp_reg[15:8] <= data_bus;
      if (bus.compose_read_enable) address_out <= comp_reg;
      if (bus.decompose_write_enable) dec_reg <= address_in;
      if (bus.decompose_read_low) data_out <= dec_reg[7:0];
      if (bus.decompose_read_high) data_out <= dec_reg[15:8];
   end
   assign obs_sig = {bus.grant, bus.compose_write_low, bus.compose_write_high, bus.compose_read_enable,
                     bus.decompose_write_enable, bus.decompose_read_low, bus.decompose_read_high,
                     bus.byte_out_valid, bus.byte_phase, bus.done, bus.error};
   assign obs_data = bus.byte_out_valid ? {8'h00, data_out} : bus.done ? address_out : 16'h0000;
   function automatic logic [11:0] mk(logic [1:0] g, logic [5:0] s, logic bov, logic ph, logic dn, logic er);
      return {g, s, bov, ph, dn, er};
   endfunction
   task automatic push(int c, logic [11:0] s, logic [15:0] d);
      exp_t x;
      x.cyc = c;
      x.sig = s;
      x.data = d;
      q.push_back(x);
   endtask
   task automatic push_dec(int t, logic [1:0] g);
      push(t + 1, mk(g, DWE, 0, 0, 0, 0), 16'h0000);
      push(t + 2, mk(g, DRL, 0, 0, 0, 0), 16'h0000);
      push(t + 3, mk(g, DRH, 1, 0, 0, 0), 16'h00EF);
      push(t + 4, mk(g, NON, 1, 1, 1, 0), 16'h00BE);
   endtask
   task automatic check(string name, logic [31:0] act, logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask
   task automatic wait_cyc(int x);
      while (cyc < x) begin
         @(posedge clock);
         #1;
      end
   endtask
   task automatic wait_accept(output int t, output logic [1:0] g);
      t = -1;
      g = 2'b00;
      for (int n = 0; n < 60; n++) begin
         @(negedge clock);
         if ((bus.req_ready & bus.req_valid) != 2'b00) begin
            t = cyc;
            g = bus.req_ready & bus.req_valid;
            return;
         end
      end
      n_cmp++;
      n_bad++;
      $display("FAIL accept_timeout: no handshake within 60 cycles, req_valid=%b", bus.req_valid);
   endtask
   // monitor: pops the scoreboard whenever the DUT shows a strobe, data byte, done or error
   always @(negedge clock) begin
      if (mon_en) begin
         while (q.size() != 0 && q[0].cyc < cyc) begin
            e = q.pop_front();
            n_cmp++;
            n_bad++;
            $display("FAIL missing_event: nothing seen at cycle %0d, expected sig %h data %h", e.cyc, e.sig, e.data);
         end
         if (|{obs_sig[9:3], obs_sig[1:0]}) begin
            n_cmp++;
            if (q.size() == 0) begin
               n_bad++;
               $display("FAIL unexpected_event: cycle %0d got sig %h data %h, expected no activity", cyc, obs_sig, obs_data);
            end else begin
               e = q.pop_front();
               if (e.cyc != cyc || e.sig !== obs_sig || e.data !== obs_data) begin
                  n_bad++;
                  $display("FAIL event: got cycle %0d sig %h data %h, expected cycle %0d sig %h data %h",
                           cyc, obs_sig, obs_data, e.cyc, e.sig, e.data);
               end
            end
         end
         check("strobe_onehot", 32'($countones(obs_sig[9:4]) <= 1), 32'd1);
         check("ready_not_both", 32'(bus.req_ready == 2'b11), 32'd0);
      end
   end
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
   initial begin
      int t, tp;
      logic [1:0] g;
      bus.req_valid = 2'b11;
      bus.req_op = 2'b00;
      bus.byte_in_valid = 1'b0;
      // reset held across two edges with both requesters valid
      repeat (2) @(posedge clock);
      #1;
      check("reset_outputs", 32'({obs_sig, bus.busy}), 32'd0);
      check("reset_ready", 32'(bus.req_ready), 32'd0);
      reset = 1'b0;
      @(negedge clock);
      check("post_reset_ready", 32'(bus.req_ready), 32'b01);
      bus.req_valid = 2'b00;
      mon_en = 1'b1;
      // decompose by requester 0
      wait_cyc(cyc + 1);
      bus.req_valid = 2'b01;
      bus.req_op = 2'b01;
      wait_accept(t, g);
      check("dec_grant", 32'(g), 32'b01);
      push_dec(t, 2'b01);
      wait_cyc(t + 1);
      bus.req_valid = 2'b00;
      check("dec_busy", 32'({bus.busy, bus.grant}), 32'b101);
      wait_cyc(t + 4);
      check("dec_ready_in_done", 32'(bus.req_ready), 32'd0);
      wait_cyc(t + 5);
      check("dec_idle", 32'({bus.busy, bus.grant}), 32'd0);
      // compose by requester 1 with a three-cycle stall on the low byte
      bus.req_valid = 2'b10;
      bus.req_op = 2'b00;
      wait_accept(t, g);
      check("comp_grant", 32'(g), 32'b10);
      push(t + 4, mk(2'b10, CWL, 0, 0, 0, 0), 16'h0000);
      push(t + 5, mk(2'b10, CWH, 0, 1, 0, 0), 16'h0000);
      push(t + 6, mk(2'b10, CRE, 0, 0, 0, 0), 16'h0000);
      push(t + 7, mk(2'b10, NON, 0, 0, 1, 0), 16'h1234);
      wait_cyc(t + 1);
      bus.req_valid = 2'b00;
      wait_cyc(t + 4);
      bus.byte_in_valid = 1'b1;
      data_bus = 8'h34;
      wait_cyc(t + 5);
      data_bus = 8'h12;
      wait_cyc(t + 6);
      bus.byte_in_valid = 1'b0;
      wait_cyc(t + 8);
      // round-robin with both requesters valid throughout
      bus.req_valid = 2'b11;
      bus.req_op = 2'b11;
      tp = 0;
      for (int i = 0; i < 4; i++) begin
         wait_accept(t, g);
         check("rr_grant", 32'(g), (i % 2 == 0) ? 32'b01 : 32'b10);
         if (i > 0) check("rr_spacing", 32'(t - tp), 32'd5);
         tp = t;
         push_dec(t, (i % 2 == 0) ? 2'b01 : 2'b10);
      end
      wait_cyc(t + 1);
      bus.req_valid = 2'b00;
      wait_cyc(t + 6);
      // compose with no bytes ever: abort after the timeout
      bus.req_valid = 2'b01;
      bus.req_op = 2'b00;
      wait_accept(t, g);
      check("to_grant", 32'(g), 32'b01);
      push(t + 1 + TO, mk(2'b01, NON, 0, 0, 0, 1), 16'h0000);
      wait_cyc(t + 1);
      bus.req_valid = 2'b00;
      wait_cyc(t + TO);
      check("to_busy_before", 32'(bus.busy), 32'd1);
      wait_cyc(t + TO + 2);
      check("to_idle_after", 32'({bus.busy, bus.grant}), 32'd0);
      // reset while in C_HIGH
      bus.req_valid = 2'b10;
      wait_accept(t, g);
      check("rst_grant", 32'(g), 32'b10);
      push(t + 1, mk(2'b10, CWL, 0, 0, 0, 0), 16'h0000);
      wait_cyc(t + 1);
      bus.req_valid = 2'b00;
      bus.byte_in_valid = 1'b1;
      data_bus = 8'h56;
      wait_cyc(t + 2);
      bus.byte_in_valid = 1'b0;
      check("rst_in_c_high", 32'(bus.byte_phase), 32'd1);
      reset = 1'b1;
      wait_cyc(t + 3);
      check("rst_outputs", 32'({obs_sig, bus.busy}), 32'd0);
      reset = 1'b0;
      bus.req_valid = 2'b11;
      bus.req_op = 2'b11;
      #1;
      check("rst_tie_ready", 32'(bus.req_ready), 32'b01);
      wait_accept(t, g);
      check("rst_tie_grant", 32'(g), 32'b01);
      push_dec(t, 2'b01);
      wait_cyc(t + 1);
      bus.req_valid = 2'b00;
      wait_cyc(t + 7);
      check("scoreboard_drained", 32'(q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
